pad: RTL and testbench
======================

Name: pad

Overview:
- Keccak/SHAKE256 message-padding stage for the final (partial) block of a message at rate 1088.
- Takes up to RATE message bits plus a bit count, and appends the SHAKE domain suffix "1111" and the pad10*1 rule.
- Emits one or two RATE-bit blocks for the absorb stage.
- Registered: one clock, one cycle latency, sits between the message buffer and the sponge absorber.

Parameters:
- RATE, 1088, block/rate width in bits.
- LEN_W, 11, width of data_length; must satisfy 2**LEN_W > RATE.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  data_in/data_length are valid this cycle
- data_in  input  RATE  message bits, MSB-first: bit RATE-1 is the first message bit
- data_length  input  LEN_W  number of valid message bits (0..RATE)
- out_valid  output  1  data_out/data_next/two_blocks valid
- data_out  output  RATE  first padded block, MSB-first
- data_next  output  RATE  second padded block; all-zero when two_blocks=0
- two_blocks  output  1  padding spilled into data_next

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): out_valid=0, two_blocks=0, data_out=0, data_next=0.
- Latency: when in_valid=1 at edge N, the results appear after edge N with out_valid=1 for exactly one cycle. Back-to-back inputs are accepted every cycle. No backpressure.
- Outputs hold their last values while out_valid=0.
- Let L = min(data_length, RATE).
  - Values above RATE saturate to RATE.
  - Input bits below the top L positions are ignored and forced to 0.
- Padded string P = M(L bits) || "1111" || "1" || 0^j || "1", where j = (-(L+6)) mod RATE.
  - data_out = P[0..RATE-1]; data_next = P[RATE..2*RATE-1].
- L <= RATE-6 (1082):
  - Single block, two_blocks=0, data_next=0.
  - The final "1" sits at data_out[0].
- L in RATE-5..RATE (1083..1088):
  - two_blocks=1.
  - The suffix and first pad bit fill the low bits of data_out; the remainder starts at data_next[RATE-1].
  - data_next[0]=1.
- L=0: data_out = 0xF8 followed by zeros, with data_out[0]=1.
- Combinational core is pure bit placement: build a thermometer mask from L and OR in a 5-bit tail pattern at position L (spanning both blocks).
- No arithmetic beyond comparison and subtraction on LEN_W bits.
- rst asserted in the same cycle as in_valid: reset wins, and out_valid stays 0 on the next cycle.

Optional Feature:
- Macro PAD_SHA3_SUFFIX_EN.
  - Defined: domain suffix is "01" (SHA3-256 mode). P = M || "01" || "1" || 0^j || "1", with j = (-(L+4)) mod RATE, and single-block threshold L <= RATE-4.
  - Undefined: SHAKE "1111" suffix exactly as above.

Decomposition:
- Package pad_pkg:
  - RATE, LEN_W defaults
  - SUFFIX pattern and SUFFIX_LEN (selected by PAD_SHA3_SUFFIX_EN)
  - typedef block_t = logic [RATE-1:0]
- Sub-module pad_mask_gen: combinational; L -> block_t keep-mask (top L bits set) plus one-hot insertion position across the two blocks.
- pad instantiates pad_mask_gen and the output registers.

Test Plan:
- data_in=0, data_length=1087 -> data_out=0x000…0001; data_next=0xF000…0001; two_blocks=1.
- data_in={5'b10011,0…}, data_length=5 -> data_out top 10 bits 1001111111, then zeros, bit0=1 (0x9FC0…0001); data_next=0; two_blocks=0.
- data_length=1082, data_in=all ones -> data_out all ones (message + 111111); two_blocks=0.
- data_length=1088, data_in=all ones -> data_out all ones; data_next=0xF800…0001; two_blocks=1.
- data_length=0 -> data_out=0xF800…0001, data_next=0. data_length=2047 behaves as 1088. Garbage below L is masked.
- in_valid pulses on consecutive cycles, then rst mid-stream -> out_valid follows in_valid one cycle later; rst clears all outputs on the next edge.

Source files
------------

// File: rtl/pad_pkg.sv
// Shared constants and types for the Keccak final-block padder.
// PAD_SHA3_SUFFIX_EN selects the SHA3 "01" domain suffix instead of SHAKE "1111".
package pad_pkg;

  localparam int RATE  = 1088;
  localparam int LEN_W = 11;

`ifdef PAD_SHA3_SUFFIX_EN
  localparam int                    SUFFIX_LEN = 2;
  localparam logic [SUFFIX_LEN-1:0] SUFFIX     = 2'b01;
`else
  localparam int                    SUFFIX_LEN = 4;
  localparam logic [SUFFIX_LEN-1:0] SUFFIX     = 4'b1111;
`endif

  // Domain suffix followed by the leading pad10*1 bit, inserted right after the message.
  localparam int                  TAIL_LEN = SUFFIX_LEN + 1;
  localparam logic [TAIL_LEN-1:0] TAIL     = {SUFFIX, 1'b1};

  typedef logic [RATE-1:0] block_t;

endpackage

// File: rtl/pad_mask_gen.sv
// Turns a message bit count into a keep-mask for the first block and a one-hot
// insertion point spanning both blocks (bit 2*RATE-1 = first bit of data_out).
module pad_mask_gen
  import pad_pkg::*;
(
  input  logic [LEN_W-1:0]  len,
  output block_t            keep,
  output logic [2*RATE-1:0] pos,
  output logic              two_blk
);

  localparam logic [LEN_W-1:0]  RATE_L  = LEN_W'(RATE);
  // Smallest length whose tail leaves no room for the final pad bit in data_out.
  localparam logic [LEN_W-1:0]  SPILL_L = LEN_W'(RATE - TAIL_LEN);
  localparam block_t            ONES    = '1;
  localparam logic [2*RATE-1:0] POS_TOP = {1'b1, {(2*RATE-1){1'b0}}};

  logic [LEN_W-1:0] l_sat;

  assign l_sat   = (len > RATE_L) ? RATE_L : len;
  assign keep    = ~(ONES >> l_sat);
  assign pos     = POS_TOP >> l_sat;
  assign two_blk = (l_sat >= SPILL_L);

endmodule

// File: rtl/pad.sv
// Final-block padder: message || domain suffix || pad10*1, one or two RATE-bit blocks,
// one cycle latency. Build with PAD_SHA3_SUFFIX_EN for the SHA3 "01" suffix.
module pad
  import pad_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [RATE-1:0]  data_in,
  input  logic [LEN_W-1:0] data_length,
  output logic             out_valid,
  output logic [RATE-1:0]  data_out,
  output logic [RATE-1:0]  data_next,
  output logic             two_blocks
);

  block_t            keep;
  logic [2*RATE-1:0] pos;
  logic              two_blk;
  logic [2*RATE-1:0] tail_acc [TAIL_LEN+1];
  logic [2*RATE-1:0] padded;

  logic              vld_p1;
  logic              two_p1;
  block_t            out_p1;
  block_t            next_p1;

  pad_mask_gen u_mask_gen (
    .len     (data_length),
    .keep    (keep),
    .pos     (pos),
    .two_blk (two_blk)
  );

  // Tail bit g lands g places after the insertion point, possibly crossing into data_next.
  assign tail_acc[0] = '0;
  for (genvar g = 0; g < TAIL_LEN; g++) begin : g_tail
    assign tail_acc[g+1] = tail_acc[g] | (TAIL[TAIL_LEN-1-g] ? (pos >> g) : '0);
  end

  always_comb begin
    padded = {data_in & keep, {RATE{1'b0}}} | tail_acc[TAIL_LEN];
    if (two_blk) padded[0]    = 1'b1;
    else         padded[RATE] = 1'b1;
  end

  // ---- stage p1: output registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      two_p1  <= 1'b0;
      out_p1  <= '0;
      next_p1 <= '0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        two_p1  <= two_blk;
        out_p1  <= padded[2*RATE-1:RATE];
        next_p1 <= padded[RATE-1:0];
      end
    end
  end

  assign out_valid  = vld_p1;
  assign two_blocks = two_p1;
  assign data_out   = out_p1;
  assign data_next  = next_p1;

endmodule

// File: tb/tb_pad.sv
// Self-checking bench for pad: bit-queue reference model of the padded string.
module tb_pad;
  import pad_pkg::*;

`ifdef PAD_SHA3_SUFFIX_EN
  localparam string SFX = "01";
`else
  localparam string SFX = "1111";
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [RATE-1:0]  data_in;
  logic [LEN_W-1:0] data_length;
  logic             out_valid;
  logic [RATE-1:0]  data_out;
  logic [RATE-1:0]  data_next;
  logic             two_blocks;

  int checks = 0;
  int errors = 0;

  block_t exp_out, exp_next;
  logic   exp_two;

  pad dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .data_in     (data_in),
    .data_length (data_length),
    .out_valid   (out_valid),
    .data_out    (data_out),
    .data_next   (data_next),
    .two_blocks  (two_blocks)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [RATE-1:0] obs, input logic [RATE-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got hi=%h lo=%h required hi=%h lo=%h", tag,
             obs[RATE-1 -: 64], obs[63:0], exp[RATE-1 -: 64], exp[63:0]);
    end
  endtask

  // Reference: build P bit by bit, then lay it MSB-first into the two blocks.
  task automatic model(input logic [RATE-1:0] din, input int len,
                       output block_t eo, output block_t en, output logic et);
    bit p[$];
    int l;
    l = (len > RATE) ? RATE : len;
    for (int i = 0; i < l; i++) p.push_back(din[RATE-1-i]);
    for (int i = 0; i < SFX.len(); i++) p.push_back(SFX[i] == 8'h31);
    p.push_back(1'b1);
    while ((p.size() % RATE) != RATE - 1) p.push_back(1'b0);
    p.push_back(1'b1);
    eo = '0;
    en = '0;
    for (int k = 0; k < p.size(); k++) begin
      if (k < RATE) eo[RATE-1-k] = p[k];
      else          en[2*RATE-1-k] = p[k];
    end
    et = (p.size() > RATE);
  endtask

  function automatic block_t rnd_block();
    block_t v;
    for (int i = 0; i < RATE/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_all(input string tag, input logic vld);
    chk({tag, ".out_valid"},  RATE'(out_valid),  RATE'(vld));
    chk({tag, ".data_out"},   data_out,          exp_out);
    chk({tag, ".data_next"},  data_next,         exp_next);
    chk({tag, ".two_blocks"}, RATE'(two_blocks), RATE'(exp_two));
  endtask

  task automatic apply(input string tag, input logic [RATE-1:0] din, input int len);
    in_valid    = 1'b1;
    data_in     = din;
    data_length = LEN_W'(len);
    model(din, len, exp_out, exp_next, exp_two);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_all(tag, 1'b1);
  endtask

  block_t ones;
  block_t k0;
  block_t pat;
  int     len;

  initial begin
    ones        = '1;
    rst         = 1'b1;
    in_valid    = 1'b0;
    data_in     = '0;
    data_length = '0;
    repeat (2) @(posedge clk);
    #1;
    exp_out  = '0;
    exp_next = '0;
    exp_two  = 1'b0;
    check_all("reset", 1'b0);
    rst = 1'b0;

    apply("len1087_zero", '0, 1087);
`ifndef PAD_SHA3_SUFFIX_EN
    k0 = '0;
    k0[RATE-1 -: 4] = 4'hF;
    k0[0] = 1'b1;
    chk("len1087_const_next", data_next, k0);
    k0 = '0;
    k0[RATE-1 -: 8] = 8'hF8;
    k0[0] = 1'b1;
`endif
    pat = '0;
    pat[RATE-1 -: 5] = 5'b10011;
    apply("len5", pat, 5);
    apply("len1082_ones", ones, 1082);
    apply("len1083_ones", ones, 1083);
    apply("len1088_ones", ones, 1088);
    apply("len0", rnd_block(), 0);
`ifndef PAD_SHA3_SUFFIX_EN
    chk("len0_const_out", data_out, k0);
`endif
    apply("len2047", rnd_block(), 2047);
    apply("len1089", rnd_block(), 1089);
    apply("len1084_rnd", rnd_block(), 1084);
    apply("len1085_rnd", rnd_block(), 1085);

    // Idle cycle with garbage on the inputs: outputs hold, out_valid low.
    data_in     = rnd_block();
    data_length = LEN_W'($urandom_range(0, 2047));
    @(posedge clk);
    #1;
    check_all("hold", 1'b0);

    for (int n = 0; n < 40; n++) begin
      if (n % 2 == 0) len = $urandom_range(1075, 1095);
      else            len = $urandom_range(0, 2047);
      apply("random", rnd_block(), len);
    end

    // Back-to-back, then reset while in_valid is high.
    apply("b2b_a", rnd_block(), 300);
    apply("b2b_b", rnd_block(), 1086);
    rst         = 1'b1;
    in_valid    = 1'b1;
    data_in     = rnd_block();
    data_length = LEN_W'(17);
    @(posedge clk);
    #1;
    exp_out  = '0;
    exp_next = '0;
    exp_two  = 1'b0;
    check_all("rst_midstream", 1'b0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_all("after_rst", 1'b0);
    apply("post_rst", rnd_block(), 1087);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
